// File: rtl/chan_pkg.sv
// Shared types, constants and helpers for the channel error injector.
package chan_pkg;

  typedef logic [1:0] sym_t;

  typedef enum logic [1:0] {CLEAN, BURST, DONE} chan_state_e;

  // Galois taps for x^16+x^14+x^13+x^11+1 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  function automatic logic [1:0] popcount2(input sym_t m);
    return {m[1] & m[0], m[1] ^ m[0]};
  endfunction

endpackage

// File: rtl/chan_lfsr.sv
// 16-bit Galois LFSR that advances only when step_i is high.
module chan_lfsr
  import chan_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_i,
  output logic [15:0] state_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_o <= SEED;
    end else if (step_i) begin
      state_o <= lfsr_next(state_o);
    end
  end

endmodule

// File: rtl/chan_err_injector.sv
// Channel stage: registers coded symbols and injects LFSR-driven error bursts
// inside an observation window. Define CHAN_ERR_STATS_EN to keep the counters.
module chan_err_injector
  import chan_pkg::*;
#(
  parameter int          N         = 5,
  parameter int          BURST_LEN = 4,
  parameter int          WINDOW    = 256,
  parameter logic [15:0] SEED      = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  sym_t        d_in,
  input  logic        inject_en_i,
  output logic        valid_o,
  output sym_t        d_out,
  output sym_t        err_inj_o,
  output logic [15:0] error_count_o,
  output logic [15:0] bad_bit_count_o
);

  localparam logic [15:0] TRIG_MASK = 16'((1 << N) - 1);
  localparam logic [15:0] WIN       = 16'(WINDOW);
  localparam logic [3:0]  BLEN      = 4'(BURST_LEN);

  // Handshake: valid_o is enable_i delayed one cycle; there is no ready, so
  // the consumer must take d_out on every cycle valid_o is high.

  logic [15:0] lfsr;
  chan_state_e state;
  logic [15:0] sym_ct;
  logic [3:0]  burst_ct;

  logic        trigger;
  logic        window_open;
  logic [15:0] sym_ct_nxt;
  logic        window_hit;
  logic        burst_start;
  logic        inject;
  sym_t        mask;
  sym_t        applied;

  chan_lfsr #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .step_i  (enable_i),
    .state_o (lfsr)
  );

  // Trigger and mask come from the pre-step LFSR value.
  assign trigger     = (lfsr & TRIG_MASK) == TRIG_MASK;
  assign mask        = lfsr[15:14];
  assign window_open = sym_ct < WIN;
  assign sym_ct_nxt  = window_open ? sym_ct + 16'd1 : sym_ct;
  assign window_hit  = (state != DONE) && (sym_ct_nxt == WIN);
  assign burst_start = (state == CLEAN) && window_open && inject_en_i && trigger;

  always_comb begin
    inject = 1'b0;
    case (state)
      CLEAN:   inject = burst_start;
      BURST:   inject = inject_en_i;
      default: inject = 1'b0;
    endcase
  end

  assign applied = inject ? mask : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAN;
      sym_ct    <= 16'd0;
      burst_ct  <= 4'd0;
      valid_o   <= 1'b0;
      d_out     <= 2'b00;
      err_inj_o <= 2'b00;
    end else begin
      valid_o <= enable_i;
      if (enable_i) begin
        d_out     <= d_in ^ applied;
        err_inj_o <= applied;
        sym_ct    <= sym_ct_nxt;
        case (state)
          CLEAN: begin
            if (burst_start) begin
              burst_ct <= 4'd1;
              if (BLEN != 4'd1) state <= BURST;
            end
          end
          BURST: begin
            // The slot is consumed even when injection is masked off.
            burst_ct <= burst_ct + 4'd1;
            if (burst_ct + 4'd1 == BLEN) state <= CLEAN;
          end
          default: ;
        endcase
        // Window closure overrides and truncates any burst in flight.
        if (window_hit) state <= DONE;
      end
    end
  end

`ifdef CHAN_ERR_STATS_EN
  logic [15:0] err_ct;
  logic [15:0] bad_ct;
  logic [16:0] bad_sum;

  assign bad_sum = {1'b0, bad_ct} + {15'd0, popcount2(mask)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ct <= 16'd0;
      bad_ct <= 16'd0;
    end else if (enable_i && inject) begin
      if (err_ct != 16'hFFFF) err_ct <= err_ct + 16'd1;
      bad_ct <= bad_sum[16] ? 16'hFFFF : bad_sum[15:0];
    end
  end

  assign error_count_o   = err_ct;
  assign bad_bit_count_o = bad_ct;
`else
  assign error_count_o   = 16'd0;
  assign bad_bit_count_o = 16'd0;
`endif

endmodule
